// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types, constants and helpers for the sprite layer.
//   SCREEN_W/SCREEN_H : visible raster size
//   COLOR_W           : bits per colour channel
//   rgb_t             : one pixel {red, green, blue}
//   anim_state_e      : animation controller states
//   in_box()          : true when (x,y) lies inside the w x h box at (px,py)
package sprite_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COLOR_W  = 4;

    typedef struct packed {
        logic [COLOR_W-1:0] red;
        logic [COLOR_W-1:0] green;
        logic [COLOR_W-1:0] blue;
    } rgb_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } anim_state_e;

    // 11-bit signed differences: negative offsets fall outside, so a sprite
    // hanging off the right/bottom edge clips instead of wrapping.
    function automatic logic in_box(input logic [9:0] x, input logic [9:0] y,
                                    input logic [9:0] px, input logic [9:0] py,
                                    input int w, input int h);
        logic signed [10:0] dx;
        logic signed [10:0] dy;
        dx = $signed({1'b0, x}) - $signed({1'b0, px});
        dy = $signed({1'b0, y}) - $signed({1'b0, py});
        return (dx >= 11'sd0) && (int'(dx) < w) &&
               (dy >= 11'sd0) && (int'(dy) < h);
    endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl: animation frame sequencer.
//   clk, rst_n   : clock, async active-low reset
//   frame_start  : one-cycle pulse per video frame
//   anim_en      : 1 = animate, 0 = hold frame 0 (only looked at on frame_start)
//   frame_idx    : current animation frame, changes only on frame_start
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | not animating; frame_idx and tick held at 0
//   ST_RUN  | counting frame_start pulses; every FRAME_TICKS advance frame
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int FRAMES      = 4,
    parameter int FRAME_TICKS = 8,
    localparam int FIDX_W     = (FRAMES > 1) ? $clog2(FRAMES) : 1,
    localparam int TICK_W     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              anim_en,
    output logic [FIDX_W-1:0] frame_idx
);

    anim_state_e       state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [FIDX_W-1:0] frame_q, frame_d;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        frame_d = frame_q;
        if (frame_start) begin
            case (state_q)
                ST_IDLE: begin
                    tick_d  = '0;
                    frame_d = '0;
                    if (anim_en) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!anim_en) begin
                        state_d = ST_IDLE;
                        tick_d  = '0;
                        frame_d = '0;
                    end else if (tick_q == TICK_W'(FRAME_TICKS - 1)) begin
                        tick_d  = '0;
                        frame_d = (frame_q == FIDX_W'(FRAMES - 1)) ? '0
                                                                 : frame_q + FIDX_W'(1);
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

    assign frame_idx = frame_q;

endmodule

// File: rtl/sprite_layer_renderer.sv
// sprite_layer_renderer: composites one animated, mirrorable, integer-scaled
// sprite over the background pixel stream. Latency 3 vga_clk cycles.
//   vga_clk, reset_n          : pixel clock, async active-low reset
//   DrawX, DrawY, blank       : raster position, 1 = active video
//   frame_start               : per-frame pulse; loads pos/flip shadows
//   pos_x, pos_y, flip_h      : sprite placement (shadowed)
//   anim_en                   : animation enable
//   bg_red/green/blue         : background pixel for DrawX/DrawY
//   rom_addr / rom_q          : synchronous sprite ROM (1-cycle read)
//   pal_idx / pal_red/green/blue : combinational palette lookup
//   red/green/blue, hit       : composited pixel, opaque-sprite flag
//   frame_idx                 : current animation frame
// Build option: define SPRITE_FLIP_V_EN to add the flip_v input (vertical mirror).
module sprite_layer_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W       = 20,
    parameter int SPR_H       = 40,
    parameter int FRAMES      = 4,
    parameter int SCALE_LOG2  = 0,
    parameter int IDX_W       = 4,
    parameter int TRANSP_IDX  = 0,
    parameter int FRAME_TICKS = 8,
    parameter int ROM_AW      = $clog2(FRAMES * SPR_W * SPR_H),
    localparam int FIDX_W     = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic               frame_start,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic               flip_h,
`ifdef SPRITE_FLIP_V_EN
    input  logic               flip_v,
`endif
    input  logic               anim_en,
    input  logic [3:0]         bg_red,
    input  logic [3:0]         bg_green,
    input  logic [3:0]         bg_blue,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [IDX_W-1:0]   rom_q,
    output logic [IDX_W-1:0]   pal_idx,
    input  logic [3:0]         pal_red,
    input  logic [3:0]         pal_green,
    input  logic [3:0]         pal_blue,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               hit,
    output logic [FIDX_W-1:0]  frame_idx
);

    localparam int BOX_W = SPR_W << SCALE_LOG2;
    localparam int BOX_H = SPR_H << SCALE_LOG2;

    logic [9:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic              flip_h_q, flip_h_d;
`ifdef SPRITE_FLIP_V_EN
    logic              flip_v_q, flip_v_d;
`endif
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              inbox_q1, inbox_q2, inbox_d;
    logic              blank_q1, blank_q2;
    rgb_t              bg_q1, bg_q2, bg_in;
    rgb_t              out_q, out_d;
    logic              hit_q, hit_d;

    logic [9:0]        dx, dy;
    int                lx, ly, addr;

    sprite_anim_ctrl #(
        .FRAMES      (FRAMES),
        .FRAME_TICKS (FRAME_TICKS)
    ) u_anim (
        .clk         (vga_clk),
        .rst_n       (reset_n),
        .frame_start (frame_start),
        .anim_en     (anim_en),
        .frame_idx   (frame_idx)
    );

    assign bg_in = '{red: bg_red, green: bg_green, blue: bg_blue};

    always_comb begin
        pos_x_d  = frame_start ? pos_x  : pos_x_q;
        pos_y_d  = frame_start ? pos_y  : pos_y_q;
        flip_h_d = frame_start ? flip_h : flip_h_q;
`ifdef SPRITE_FLIP_V_EN
        flip_v_d = frame_start ? flip_v : flip_v_q;
`endif

        // S0: box test and local source coordinates. dx/dy may wrap when the
        // pixel is left of/above the box, but then in-box is false and the
        // address is not used.
        inbox_d = in_box(DrawX, DrawY, pos_x_q, pos_y_q, BOX_W, BOX_H);
        dx      = DrawX - pos_x_q;
        dy      = DrawY - pos_y_q;
        lx      = int'(dx) >> SCALE_LOG2;
        ly      = int'(dy) >> SCALE_LOG2;
        if (flip_h_q) lx = SPR_W - 1 - lx;
`ifdef SPRITE_FLIP_V_EN
        if (flip_v_q) ly = SPR_H - 1 - ly;
`endif
        addr       = int'(frame_idx) * SPR_W * SPR_H + ly * SPR_W + lx;
        rom_addr_d = inbox_d ? ROM_AW'(addr) : rom_addr_q;

        // S3: rom_q is aligned with the stage-2 copies of blank/in-box/bg.
        out_d = '0;
        hit_d = 1'b0;
        if (blank_q2) begin
            if (inbox_q2 && (rom_q != IDX_W'(TRANSP_IDX))) begin
                out_d = '{red: pal_red, green: pal_green, blue: pal_blue};
                hit_d = 1'b1;
            end else begin
                out_d = bg_q2;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            flip_h_q   <= 1'b0;
`ifdef SPRITE_FLIP_V_EN
            flip_v_q   <= 1'b0;
`endif
            rom_addr_q <= '0;
            inbox_q1   <= 1'b0;
            inbox_q2   <= 1'b0;
            blank_q1   <= 1'b0;
            blank_q2   <= 1'b0;
            bg_q1      <= '0;
            bg_q2      <= '0;
            out_q      <= '0;
            hit_q      <= 1'b0;
        end else begin
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            flip_h_q   <= flip_h_d;
`ifdef SPRITE_FLIP_V_EN
            flip_v_q   <= flip_v_d;
`endif
            rom_addr_q <= rom_addr_d;
            inbox_q1   <= inbox_d;
            inbox_q2   <= inbox_q1;
            blank_q1   <= blank;
            blank_q2   <= blank_q1;
            bg_q1      <= bg_in;
            bg_q2      <= bg_q1;
            out_q      <= out_d;
            hit_q      <= hit_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign pal_idx  = rom_q;
    assign red      = out_q.red;
    assign green    = out_q.green;
    assign blue     = out_q.blue;
    assign hit      = hit_q;

endmodule

// File: doc/sprite_layer_renderer.md
Name: sprite_layer_renderer

Overview:
- Parametrised sprite layer for the 640x480 VGA pipeline.
- Draws one animated, optionally mirrored, integer-scaled sprite at a run-time position over an incoming background pixel stream.
- Indices with value TRANSP_IDX are transparent, so the background pixel passes through.
- Sits between the background/tilemap layer and the VGA output register. Instances can be chained, one per character.

Parameters:
- SPR_W, 20, sprite width in source pixels.
- SPR_H, 40, sprite height in source pixels.
- FRAMES, 4, animation frames stored back-to-back in the sprite ROM.
- SCALE_LOG2, 0, on-screen magnification is 2**SCALE_LOG2 in both axes.
- IDX_W, 4, palette index width.
- TRANSP_IDX, 0, palette index treated as transparent.
- FRAME_TICKS, 8, video frames per animation step (>=1).
- ROM_AW, $clog2(FRAMES*SPR_W*SPR_H), sprite ROM address width.

Ports:
- vga_clk  in  1  pixel clock; all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- frame_start  in  1  one-cycle pulse at the start of each video frame.
- pos_x  in  10  sprite top-left column; sampled at frame_start.
- pos_y  in  10  sprite top-left row; sampled at frame_start.
- flip_h  in  1  horizontal mirror; sampled at frame_start.
- anim_en  in  1  1 = animate; 0 = hold frame 0.
- bg_red, bg_green, bg_blue  in  4 each  background pixel for this DrawX/DrawY.
- rom_addr  out  ROM_AW  sprite ROM address (synchronous ROM, 1-cycle read).
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_addr.
- pal_idx  out  IDX_W  index to the combinational palette.
- pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_idx.
- red, green, blue  out  4 each  composited pixel.
- hit  out  1  opaque sprite pixel drawn this cycle (collision tap).
- frame_idx  out  $clog2(FRAMES)  current animation frame.

Behaviour:
- Reset state: red/green/blue = 0, hit = 0, rom_addr = 0, frame_idx = 0. Shadow pos_x/pos_y/flip_h = 0. Tick counter = 0. Pipeline valid bits cleared. Reset mid-frame takes effect immediately, with no partial pixel output.
- Shadowing: pos_x, pos_y and flip_h load into shadow registers only on frame_start, so no tearing occurs within a frame. Shadows update on the same edge that frame_start is seen.
- Pipeline:
  - S0: compute in-box from DrawX/DrawY versus the shadow position. Box width = SPR_W<<SCALE_LOG2, box height = SPR_H<<SCALE_LOG2.
  - S1 (rom_addr registered): rom_addr = frame_idx*SPR_W*SPR_H + ly*SPR_W + lx.
  - S2: rom_q valid, pal_idx = rom_q.
  - S3: output registered.
  - Total latency from DrawX/DrawY/blank/bg_* to red/green/blue/hit is 3 vga_clk cycles. blank, bg_* and in-box are delayed in lockstep.
- Local coordinates:
  - lx = (DrawX-pos_x)>>SCALE_LOG2 and ly = (DrawY-pos_y)>>SCALE_LOG2.
  - Use 11-bit signed arithmetic; negative or >= box size means outside.
  - Sprites partially off the right or bottom edge clip with no wrap-around.
  - flip_h: lx' = SPR_W-1-lx.
- Outside the box: rom_addr holds its last value and the sprite contributes nothing.
- Output select at S3:
  - blank delayed = 0 -> RGB = 0, hit = 0.
  - Else if in-box and rom_q != TRANSP_IDX -> RGB = pal_*, hit = 1.
  - Else -> RGB = bg_*, hit = 0.
- Animation FSM (states IDLE, RUN):
  - IDLE: frame_idx = 0, tick = 0. Move to RUN when anim_en = 1 at frame_start.
  - RUN: on each frame_start, tick increments. When tick == FRAME_TICKS-1, tick becomes 0 and frame_idx advances, wrapping FRAMES-1 -> 0.
  - anim_en = 0 seen at frame_start: return to IDLE, frame_idx = 0. anim_en changes between frame_start pulses are ignored.
  - frame_idx changes only at frame_start, never mid-frame.
- FRAMES = 1: frame_idx is constant 0 and the FSM still cycles tick harmlessly.

Optional Feature:
- Macro: SPRITE_FLIP_V_EN.
- Defined: adds input port flip_v (1 bit), shadowed at frame_start. When set, ly' = SPR_H-1-ly.
- Undefined: no flip_v port, and ly is used unmirrored.

Decomposition:
- Package sprite_pkg holds:
  - SCREEN_W = 640 and SCREEN_H = 480.
  - COLOR_W = 4.
  - typedef struct rgb_t {red, green, blue}.
  - function in_box(x, y, px, py, w, h).
- Sub-module sprite_anim_ctrl holds the IDLE/RUN FSM, tick counter and frame_idx. Parameters: FRAMES, FRAME_TICKS.

Test Plan:
- Reset mid-line with blank = 1 -> all outputs 0 within the same cycle. Once reset_n = 1, the first valid output appears 3 cycles after the first pixel.
- pos = (100,50), SPR 20x40, scale 0, ROM index at (0,0) = 5 -> pixel at DrawX = 100, DrawY = 50 shows palette[5] with hit = 1 at cycle +3. DrawX = 99 shows bg_* with hit = 0.
- Same position with flip_h = 1 -> DrawX = 100 outputs source column 19. Toggling flip_h mid-frame has no effect until the next frame_start.
- TRANSP_IDX pixel inside the box -> bg_* passes, hit = 0. Pixel with blank = 0 inside the box -> RGB = 0.
- anim_en = 1, FRAME_TICKS = 2, FRAMES = 4 -> frame_idx steps 0,0,1,1,2,2,3,3,0 over frame_start pulses. Dropping anim_en -> frame_idx = 0 at the next frame_start.
- pos_x = 630, SCALE_LOG2 = 1 -> only DrawX 630..639 drawn, with no wrap to column 0. Each source pixel is duplicated across 2 columns and 2 rows.
